// File: rtl/rf_dump_streamer.sv
// Register-file dump streamer: snapshots 32 CPU registers on start and streams
// them out over a valid/ready port, optionally only those changed since the last dump.
module rf_dump_streamer #(
  parameter bit CHANGED_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] RF_data0,
  input  logic [31:0] RF_data1,
  input  logic [31:0] RF_data2,
  input  logic [31:0] RF_data3,
  input  logic [31:0] RF_data4,
  input  logic [31:0] RF_data5,
  input  logic [31:0] RF_data6,
  input  logic [31:0] RF_data7,
  input  logic [31:0] RF_data8,
  input  logic [31:0] RF_data9,
  input  logic [31:0] RF_data10,
  input  logic [31:0] RF_data11,
  input  logic [31:0] RF_data12,
  input  logic [31:0] RF_data13,
  input  logic [31:0] RF_data14,
  input  logic [31:0] RF_data15,
  input  logic [31:0] RF_data16,
  input  logic [31:0] RF_data17,
  input  logic [31:0] RF_data18,
  input  logic [31:0] RF_data19,
  input  logic [31:0] RF_data20,
  input  logic [31:0] RF_data21,
  input  logic [31:0] RF_data22,
  input  logic [31:0] RF_data23,
  input  logic [31:0] RF_data24,
  input  logic [31:0] RF_data25,
  input  logic [31:0] RF_data26,
  input  logic [31:0] RF_data27,
  input  logic [31:0] RF_data28,
  input  logic [31:0] RF_data29,
  input  logic [31:0] RF_data30,
  input  logic [31:0] RF_data31,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               prev_valid_q;
  logic [DATA_W-1:0]  snap_q [NUM_REGS];
  logic [DATA_W-1:0]  prev_q [NUM_REGS];
  logic [DATA_W-1:0]  rf_live [NUM_REGS];
  logic               sendable_c;
  logic               capture_c;
  logic               commit_c;

  assign rf_live[0]  = RF_data0;
  assign rf_live[1]  = RF_data1;
  assign rf_live[2]  = RF_data2;
  assign rf_live[3]  = RF_data3;
  assign rf_live[4]  = RF_data4;
  assign rf_live[5]  = RF_data5;
  assign rf_live[6]  = RF_data6;
  assign rf_live[7]  = RF_data7;
  assign rf_live[8]  = RF_data8;
  assign rf_live[9]  = RF_data9;
  assign rf_live[10] = RF_data10;
  assign rf_live[11] = RF_data11;
  assign rf_live[12] = RF_data12;
  assign rf_live[13] = RF_data13;
  assign rf_live[14] = RF_data14;
  assign rf_live[15] = RF_data15;
  assign rf_live[16] = RF_data16;
  assign rf_live[17] = RF_data17;
  assign rf_live[18] = RF_data18;
  assign rf_live[19] = RF_data19;
  assign rf_live[20] = RF_data20;
  assign rf_live[21] = RF_data21;
  assign rf_live[22] = RF_data22;
  assign rf_live[23] = RF_data23;
  assign rf_live[24] = RF_data24;
  assign rf_live[25] = RF_data25;
  assign rf_live[26] = RF_data26;
  assign rf_live[27] = RF_data27;
  assign rf_live[28] = RF_data28;
  assign rf_live[29] = RF_data29;
  assign rf_live[30] = RF_data30;
  assign rf_live[31] = RF_data31;

  // Without a valid previous dump every entry must go out.
  assign sendable_c = !CHANGED_ONLY || !prev_valid_q || (snap_q[idx_q] != prev_q[idx_q]);

  assign out_valid = (state_q == S_SEND) && sendable_c;
  assign out_idx   = idx_q;
  assign out_data  = snap_q[idx_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    capture_c = 1'b0;
    commit_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture_c = 1'b1;
          idx_d     = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        // Unsendable entries are skipped without waiting for the consumer.
        if (!sendable_c || out_ready) begin
          if (idx_q == IDX_W'(NUM_REGS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        commit_c = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (commit_c) begin
        prev_valid_q <= 1'b1;
      end
    end
  end

  // Snapshot and history storage; left unreset, gated so reset blocks any update.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (capture_c && !reset) begin
        snap_q[i] <= rf_live[i];
      end
      if (commit_c && !reset) begin
        prev_q[i] <= snap_q[i];
      end
    end
  end

endmodule

// File: tb/tb_rf_dump_streamer.sv
// Randomized bench for rf_dump_streamer: two instances (all entries / changed-only)
// compared against a per-dump reference built from snapshot and previous-dump arrays.
module tb_rf_dump_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rf [32];
  logic        start_v [2];
  logic        ready_v [2];
  logic        valid_v [2];
  logic [4:0]  idx_v [2];
  logic [31:0] data_v [2];
  logic        busy_v [2];
  logic        done_v [2];

  logic [31:0] prev_m [2][32];
  bit          pv_m [2];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rf_dump_streamer #(.CHANGED_ONLY(g == 1)) u_dut (
      .clk(clk), .reset(reset), .start(start_v[g]),
      .RF_data0(rf[0]),   .RF_data1(rf[1]),   .RF_data2(rf[2]),   .RF_data3(rf[3]),
      .RF_data4(rf[4]),   .RF_data5(rf[5]),   .RF_data6(rf[6]),   .RF_data7(rf[7]),
      .RF_data8(rf[8]),   .RF_data9(rf[9]),   .RF_data10(rf[10]), .RF_data11(rf[11]),
      .RF_data12(rf[12]), .RF_data13(rf[13]), .RF_data14(rf[14]), .RF_data15(rf[15]),
      .RF_data16(rf[16]), .RF_data17(rf[17]), .RF_data18(rf[18]), .RF_data19(rf[19]),
      .RF_data20(rf[20]), .RF_data21(rf[21]), .RF_data22(rf[22]), .RF_data23(rf[23]),
      .RF_data24(rf[24]), .RF_data25(rf[25]), .RF_data26(rf[26]), .RF_data27(rf[27]),
      .RF_data28(rf[28]), .RF_data29(rf[29]), .RF_data30(rf[30]), .RF_data31(rf[31]),
      .out_valid(valid_v[g]), .out_ready(ready_v[g]), .out_idx(idx_v[g]),
      .out_data(data_v[g]), .busy(busy_v[g]), .done(done_v[g])
    );
  end

  task automatic randomize_rf();
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
  endtask

  // One dump on instance d. mode: 0 ready=1, 1 random ready, 2 three-cycle stall on idx 5.
  task automatic dump(input int d, input int mode, input bit corrupt7, input int ign_cyc,
                      input int abort_idx, input bit start_in_done);
    logic [31:0] snap [32];
    bit          sendable [32];
    int          exp_q [$];
    int          stalls = 0;
    int          cyc = 0;
    int          stall_left = 0;
    int          e;
    bit          did_bp = 0;
    bit          held = 0;
    bit          finished = 0;
    bit          done_seen = 0;
    bit          rdy;
    logic [4:0]  h_idx = '0;
    logic [31:0] h_data = '0;

    for (int k = 0; k < 32; k++) begin
      snap[k]     = rf[k];
      sendable[k] = (d == 0) || !pv_m[d] || (rf[k] != prev_m[d][k]);
      if (sendable[k]) exp_q.push_back(k);
    end
    start_v[d] = 1'b1;
    ready_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    cyc = 1;
    if (corrupt7) rf[7] = 32'hDEADBEEF;

    while (!finished && cyc < 200) begin
      start_v[d] = (cyc == ign_cyc);
      if (done_v[d] === 1'b1) begin
        n_total++;
        if (cyc != 33 + stalls) $display("FAIL done_cycle dut%0d: got %0d expected %0d", d, cyc, 33 + stalls);
        else n_pass++;
        n_total++;
        if (valid_v[d] !== 1'b0) $display("FAIL valid_in_done dut%0d: got %b expected 0", d, valid_v[d]);
        else n_pass++;
        for (int k = 0; k < 32; k++) prev_m[d][k] = snap[k];
        pv_m[d]    = 1'b1;
        done_seen  = 1'b1;
        finished   = 1'b1;
        start_v[d] = start_in_done;
        @(negedge clk);
        start_v[d] = 1'b0;
        n_total++;
        if (busy_v[d] !== 1'b0) $display("FAIL busy_after_done dut%0d: got %b expected 0", d, busy_v[d]);
        else n_pass++;
        n_total++;
        if (done_v[d] !== 1'b0) $display("FAIL done_pulse_width dut%0d: got %b expected 0", d, done_v[d]);
        else n_pass++;
      end else begin
        n_total++;
        if (busy_v[d] !== 1'b1) $display("FAIL busy_in_send dut%0d cyc %0d: got %b expected 1", d, cyc, busy_v[d]);
        else n_pass++;
        if (cyc == 1) begin
          n_total++;
          if (idx_v[d] !== 5'd0) $display("FAIL first_idx dut%0d: got %0d expected 0", d, idx_v[d]);
          else n_pass++;
        end
        if (held) begin
          n_total++;
          if ({valid_v[d], idx_v[d], data_v[d]} !== {1'b1, h_idx, h_data})
            $display("FAIL hold_stable dut%0d: got v%b idx %0d data %h expected v1 idx %0d data %h",
                     d, valid_v[d], idx_v[d], data_v[d], h_idx, h_data);
          else n_pass++;
        end
        n_total++;
        if (valid_v[d] !== sendable[idx_v[d]])
          $display("FAIL valid_decode dut%0d idx %0d: got %b expected %b", d, idx_v[d], valid_v[d], sendable[idx_v[d]]);
        else n_pass++;

        if (abort_idx >= 0 && idx_v[d] == 5'(abort_idx)) begin
          reset      = 1'b1;
          ready_v[d] = 1'b0;
          start_v[d] = 1'b0;
          @(negedge clk);
          reset = 1'b0;
          n_total++;
          if ({valid_v[d], busy_v[d], done_v[d]} !== 3'b000)
            $display("FAIL abort_outputs dut%0d: got v%b b%b d%b expected 000", d, valid_v[d], busy_v[d], done_v[d]);
          else n_pass++;
          repeat (3) begin
            @(negedge clk);
            n_total++;
            if ({valid_v[d], done_v[d]} !== 2'b00)
              $display("FAIL abort_quiet dut%0d: got v%b d%b expected 00", d, valid_v[d], done_v[d]);
            else n_pass++;
          end
          pv_m[0]    = 1'b0;
          pv_m[1]    = 1'b0;
          ready_v[d] = 1'b1;
          finished   = 1'b1;
        end else begin
          if (mode == 2 && valid_v[d] && idx_v[d] == 5'd5 && !did_bp) begin
            stall_left = 3;
            did_bp     = 1'b1;
          end
          if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end else begin
            rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          ready_v[d] = rdy;
          if (valid_v[d] && rdy) begin
            n_total++;
            if (exp_q.size() == 0) begin
              $display("FAIL extra_transfer dut%0d: got idx %0d expected none", d, idx_v[d]);
            end else begin
              e = exp_q.pop_front();
              if (idx_v[d] !== 5'(e)) $display("FAIL xfer_idx dut%0d: got %0d expected %0d", d, idx_v[d], e);
              else n_pass++;
              n_total++;
              if (data_v[d] !== snap[e]) $display("FAIL xfer_data dut%0d idx %0d: got %h expected %h", d, e, data_v[d], snap[e]);
              else n_pass++;
            end
          end
          held = valid_v[d] && !rdy;
          if (held) begin
            stalls++;
            h_idx  = idx_v[d];
            h_data = data_v[d];
          end
          @(negedge clk);
          cyc++;
        end
      end
    end
    start_v[d] = 1'b0;
    ready_v[d] = 1'b1;
    if (!finished) begin
      n_total++;
      $display("FAIL dump_timeout dut%0d: got no done after %0d cycles expected done", d, cyc);
    end
    if (done_seen) begin
      n_total++;
      if (exp_q.size() != 0) $display("FAIL missing_transfers dut%0d: got %0d left expected 0", d, exp_q.size());
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    randomize_rf();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b1;
      ready_v[d] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_total++;
      if (busy_v[d] !== 1'b0) $display("FAIL reset_busy dut%0d: got %b expected 0", d, busy_v[d]);
      else n_pass++;
      n_total++;
      if (valid_v[d] !== 1'b0) $display("FAIL reset_valid dut%0d: got %b expected 0", d, valid_v[d]);
      else n_pass++;
      n_total++;
      if (done_v[d] !== 1'b0) $display("FAIL reset_done dut%0d: got %b expected 0", d, done_v[d]);
      else n_pass++;
      start_v[d] = 1'b0;
      pv_m[d]    = 1'b0;
    end
    reset = 1'b0;
  endtask

  task automatic test_full_dump();
    for (int k = 0; k < 32; k++) rf[k] = k * 32'h11;
    dump(0, 0, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    randomize_rf();
    dump(0, 2, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_snapshot();
    randomize_rf();
    dump(0, 0, 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_random_ready();
    repeat (3) begin
      randomize_rf();
      dump(0, 1, 1'b0, 0, -1, 1'b0);
    end
  endtask

  task automatic test_changed_only();
    randomize_rf();
    dump(1, 0, 1'b0, 0, -1, 1'b0);
    rf[3]  = ~rf[3];
    rf[20] = rf[20] + 32'd1;
    dump(1, 0, 1'b0, 0, -1, 1'b0);
    dump(1, 0, 1'b0, 0, -1, 1'b0);
    repeat (2) begin
      repeat (5) rf[$urandom_range(0, 31)] = $urandom;
      dump(1, 1, 1'b0, 0, -1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    randomize_rf();
    dump(0, 0, 1'b0, 0, -1, 1'b1);
    randomize_rf();
    dump(0, 1, 1'b0, 0, -1, 1'b1);
    dump(1, 0, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_ignored_start_and_reset();
    randomize_rf();
    dump(0, 1, 1'b0, 8, -1, 1'b0);
    randomize_rf();
    dump(1, 0, 1'b0, 4, 10, 1'b0);
    dump(1, 0, 1'b0, 0, -1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      ready_v[d] = 1'b1;
      pv_m[d]    = 1'b0;
    end
    for (int k = 0; k < 32; k++) rf[k] = '0;
    @(negedge clk);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_snapshot();
    test_random_ready();
    test_changed_only();
    test_back_to_back();
    test_ignored_start_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
